// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte sequencer: bit-controller command codes,
// byte-command flag positions and the sequencer state encoding.
package i2c_pkg;

  localparam logic [2:0] BIT_CMD_IDLE  = 3'b000;
  localparam logic [2:0] BIT_CMD_START = 3'b001;
  localparam logic [2:0] BIT_CMD_WRITE = 3'b010;
  localparam logic [2:0] BIT_CMD_READ  = 3'b011;
  localparam logic [2:0] BIT_CMD_STOP  = 3'b100;

  localparam int CMD_START = 3;
  localparam int CMD_STOP  = 2;
  localparam int CMD_WRITE = 1;
  localparam int CMD_READ  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_t;

  // The ACK slot reads the slave's ACK after a WRITE and drives our ACK after a READ.
  function automatic logic [2:0] bit_cmd_of(state_t s, logic is_write);
    case (s)
      ST_START: return BIT_CMD_START;
      ST_WRITE: return BIT_CMD_WRITE;
      ST_READ:  return BIT_CMD_READ;
      ST_ACK:   return is_write ? BIT_CMD_READ : BIT_CMD_WRITE;
      ST_STOP:  return BIT_CMD_STOP;
      default:  return BIT_CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_master_byte_control_if.sv
// Host-side byte command handshake plus the bit-controller command/response lines.
interface i2c_master_byte_control_if;
  logic       i_cmd_valid;
  logic [3:0] i_cmd;
  logic [7:0] i_tx_byte;
  logic       i_ack_in;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_rx_byte;
  logic       o_ack_rx;
  logic       o_error;
  logic [2:0] o_bit_cmd;
  logic       o_bit_data;
  logic       i_bit_done;
  logic       i_bit_data;

  modport master (
    input  i_cmd_valid, i_cmd, i_tx_byte, i_ack_in, i_bit_done, i_bit_data,
    output o_busy, o_done, o_rx_byte, o_ack_rx, o_error, o_bit_cmd, o_bit_data
  );

  modport slave (
    output i_cmd_valid, i_cmd, i_tx_byte, i_ack_in, i_bit_done, i_bit_data,
    input  o_busy, o_done, o_rx_byte, o_ack_rx, o_error, o_bit_cmd, o_bit_data
  );
endinterface

// File: rtl/i2c_byte_shifter.sv
// 8-bit load/shift register with a 7->0 bit counter; MSB is the TX bit, LSB takes RX bits.
module i2c_byte_shifter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_byte,
  input  logic       i_shift,
  input  logic       i_shift_in,
  output logic [7:0] o_byte,
  output logic       o_last
);
  logic [7:0] r_shift;
  logic [2:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= 8'h00;
      r_cnt   <= 3'd7;
    end else if (i_load) begin
      r_shift <= i_load_byte;
      r_cnt   <= 3'd7;
    end else if (i_shift) begin
      r_shift <= {r_shift[6:0], i_shift_in};
      r_cnt   <= r_cnt - 3'd1;
    end
  end

  assign o_byte = r_shift;
  assign o_last = (r_cnt == 3'd0);
endmodule

// File: rtl/i2c_master_byte_control.sv
// Byte-level sequencer driving master_bit_control. Optional watchdog abort is
// enabled by defining I2C_BYTE_TIMEOUT_EN.
module i2c_master_byte_control
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                       i_clk_master,
  input logic                       i_reset_n,
  i2c_master_byte_control_if.master io_bus
);

  state_t     r_state;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic [7:0] r_rx_byte;
  logic       r_ack_rx;
  logic [2:0] r_bit_cmd;
  logic       r_bit_data;
  logic       r_f_stop;
  logic       r_f_write;
  logic       r_f_read;
  logic       r_ack_in;

  logic       w_accept;
  logic       w_wr;
  logic       w_rd;
  state_t     w_first;
  state_t     w_adv_state;
  logic       w_adv_msb;
  logic       w_shift;
  logic       w_last;
  logic [7:0] w_byte;

  function automatic state_t after_start(logic stop, logic wr, logic rd);
    if (wr)   return ST_WRITE;
    if (rd)   return ST_READ;
    if (stop) return ST_STOP;
    return ST_DONE;
  endfunction

  // READ-type slots leave SDA released; the ACK after a READ carries the host's ACK level.
  function automatic logic bit_data_of(state_t s, logic msb, logic is_write, logic ack_lvl);
    case (s)
      ST_WRITE: return msb;
      ST_READ:  return 1'b1;
      ST_ACK:   return is_write ? 1'b1 : ack_lvl;
      default:  return 1'b0;
    endcase
  endfunction

  assign w_accept = io_bus.i_cmd_valid && !r_busy;
  assign w_wr     = io_bus.i_cmd[CMD_WRITE];
  assign w_rd     = io_bus.i_cmd[CMD_READ] && !io_bus.i_cmd[CMD_WRITE];
  assign w_first  = io_bus.i_cmd[CMD_START] ? ST_START
                                            : after_start(io_bus.i_cmd[CMD_STOP], w_wr, w_rd);
  assign w_shift  = ((r_state == ST_WRITE) || (r_state == ST_READ)) &&
                    (r_bit_cmd != BIT_CMD_IDLE) && io_bus.i_bit_done;

  i2c_byte_shifter u_shifter (
    .i_clk       (i_clk_master),
    .i_rst_n     (i_reset_n),
    .i_load      (w_accept),
    .i_load_byte (io_bus.i_tx_byte),
    .i_shift     (w_shift),
    .i_shift_in  (io_bus.i_bit_data),
    .o_byte      (w_byte),
    .o_last      (w_last)
  );

  // Successor of the current bit slot; inside WRITE the next MSB is bit 6 because the shift lands on the same edge.
  always_comb begin
    w_adv_state = ST_DONE;
    w_adv_msb   = w_byte[7];
    case (r_state)
      ST_START: w_adv_state = after_start(r_f_stop, r_f_write, r_f_read);
      ST_WRITE: begin
        w_adv_state = w_last ? ST_ACK : ST_WRITE;
        w_adv_msb   = w_byte[6];
      end
      ST_READ:  w_adv_state = w_last ? ST_ACK : ST_READ;
      ST_ACK:   w_adv_state = r_f_stop ? ST_STOP : ST_DONE;
      default:  w_adv_state = ST_DONE;
    endcase
  end

`ifdef I2C_BYTE_TIMEOUT_EN
  localparam logic [11:0] WD_LIMIT = 12'(TIMEOUT_CYCLES - 1);
  logic [11:0] r_wdog;
  logic        w_new_cmd;

  assign w_new_cmd = (r_state != ST_IDLE) && (r_state != ST_DONE) &&
                     ((r_bit_cmd == BIT_CMD_IDLE) || io_bus.i_bit_done);

  always_ff @(posedge i_clk_master or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wdog <= 12'd0;
    end else if (w_new_cmd) begin
      r_wdog <= 12'd0;
    end else if (r_bit_cmd != BIT_CMD_IDLE) begin
      r_wdog <= r_wdog + 12'd1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge i_clk_master or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_ack_rx   <= 1'b1;
      r_bit_cmd  <= BIT_CMD_IDLE;
      r_bit_data <= 1'b0;
      r_f_stop   <= 1'b0;
      r_f_write  <= 1'b0;
      r_f_read   <= 1'b0;
      r_ack_in   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state    <= ST_IDLE;
          r_bit_cmd  <= BIT_CMD_IDLE;
          r_bit_data <= 1'b0;
          if (w_accept) begin
            r_f_stop  <= io_bus.i_cmd[CMD_STOP];
            r_f_write <= w_wr;
            r_f_read  <= w_rd;
            r_ack_in  <= io_bus.i_ack_in;
            if (w_first == ST_DONE) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= w_first;
              r_busy  <= 1'b1;
            end
          end
        end
        default: begin
          if (r_bit_cmd == BIT_CMD_IDLE) begin
            r_bit_cmd  <= bit_cmd_of(r_state, r_f_write);
            r_bit_data <= bit_data_of(r_state, w_byte[7], r_f_write, r_ack_in);
          end else if (io_bus.i_bit_done) begin
            if (r_state == ST_ACK) begin
              if (r_f_write) r_ack_rx  <= io_bus.i_bit_data;
              else           r_rx_byte <= w_byte;
            end
            r_state    <= w_adv_state;
            r_bit_cmd  <= bit_cmd_of(w_adv_state, r_f_write);
            r_bit_data <= bit_data_of(w_adv_state, w_adv_msb, r_f_write, r_ack_in);
            if (w_adv_state == ST_DONE) begin
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end
          end
`ifdef I2C_BYTE_TIMEOUT_EN
          else if (r_wdog == WD_LIMIT) begin
            r_state    <= ST_DONE;
            r_bit_cmd  <= BIT_CMD_IDLE;
            r_bit_data <= 1'b0;
            r_done     <= 1'b1;
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
          end
`endif
        end
      endcase
    end
  end

  assign io_bus.o_busy     = r_busy;
  assign io_bus.o_done     = r_done;
  assign io_bus.o_error    = r_error;
  assign io_bus.o_rx_byte  = r_rx_byte;
  assign io_bus.o_ack_rx   = r_ack_rx;
  assign io_bus.o_bit_cmd  = r_bit_cmd;
  assign io_bus.o_bit_data = r_bit_data;

endmodule

// File: tb/tb_i2c_master_byte_control.sv
// Directed bench for i2c_master_byte_control with a bit-controller model answering 5 cycles after each command.
module tb_i2c_master_byte_control;

  logic clk;
  logic rst_n;
  logic model_en;
  logic [7:0] resp_byte;
  logic [2:0] rd_idx;
  int bm_cnt;
  int n_log;
  int n_done;
  int n_err;
  logic [2:0] log_cmd [0:255];
  logic       log_dat [0:255];
  int errors;
  int checks;

  i2c_master_byte_control_if bus ();

  i2c_master_byte_control #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk_master (clk),
    .i_reset_n    (rst_n),
    .io_bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-controller model: log each command when it answers; READ slots return resp_byte MSB first.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_bit_done <= 1'b0;
      bus.i_bit_data <= 1'b0;
      bm_cnt         <= 0;
      rd_idx         <= 3'd0;
    end else begin
      bus.i_bit_done <= 1'b0;
      if (bus.o_done) rd_idx <= 3'd0;
      if (bus.i_bit_done) begin
        bm_cnt <= 0;
      end else if (bus.o_bit_cmd != 3'b000 && model_en) begin
        if (bm_cnt == 4) begin
          bus.i_bit_done <= 1'b1;
          bm_cnt         <= 0;
          if (n_log < 256) begin
            log_cmd[n_log] <= bus.o_bit_cmd;
            log_dat[n_log] <= bus.o_bit_data;
          end
          n_log <= n_log + 1;
          if (bus.o_bit_cmd == 3'b011) begin
            bus.i_bit_data <= resp_byte[3'd7 - rd_idx];
            rd_idx         <= rd_idx + 3'd1;
          end else begin
            bus.i_bit_data <= 1'b0;
          end
        end else begin
          bm_cnt <= bm_cnt + 1;
        end
      end else begin
        bm_cnt <= 0;
      end
    end
  end

  always @(posedge clk) begin
    if (bus.o_done)  n_done <= n_done + 1;
    if (bus.o_error) n_err  <= n_err + 1;
  end

  task automatic send(input logic [3:0] c, input logic [7:0] tx, input logic ack);
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    bus.i_tx_byte   = tx;
    bus.i_ack_in    = ack;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", bus.o_done); end
    checks++; if (bus.o_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", bus.o_error); end
    checks++; if (bus.o_rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx got=%h exp=00", bus.o_rx_byte); end
    checks++; if (bus.o_ack_rx !== 1'b1) begin errors++; $display("FAIL reset_ack_rx got=%0b exp=1", bus.o_ack_rx); end
    checks++; if (bus.o_bit_cmd !== 3'b000) begin errors++; $display("FAIL reset_bit_cmd got=%b exp=000", bus.o_bit_cmd); end
    checks++; if (bus.o_bit_data !== 1'b0) begin errors++; $display("FAIL reset_bit_data got=%0b exp=0", bus.o_bit_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty;
    int base;
    base = n_log;
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = 4'b0000;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    checks++; if (bus.o_done !== 1'b1) begin errors++; $display("FAIL empty_done got=%0b exp=1", bus.o_done); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL empty_busy got=%0b exp=0", bus.o_busy); end
    @(negedge clk);
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL empty_done_pulse got=%0b exp=0", bus.o_done); end
    repeat (10) @(negedge clk);
    checks++; if (n_log !== base) begin errors++; $display("FAIL empty_no_bits got=%0d exp=%0d", n_log, base); end
  endtask

  task automatic test_write;
    int base;
    int d0;
    bit ok;
    logic [7:0] tx;
    logic [2:0] ec;
    tx = 8'hA5;
    resp_byte = 8'h00;
    base = n_log;
    d0 = n_done;
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = 4'b1110;
    bus.i_tx_byte   = tx;
    bus.i_ack_in    = 1'b0;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL write_busy got=%0b exp=1", bus.o_busy); end
    checks++; if (bus.o_bit_cmd !== 3'b000) begin errors++; $display("FAIL write_first_lat got=%b exp=000", bus.o_bit_cmd); end
    @(negedge clk);
    checks++; if (bus.o_bit_cmd !== 3'b001) begin errors++; $display("FAIL write_start got=%b exp=001", bus.o_bit_cmd); end
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_timeout got=no_done exp=done"); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL write_busy_at_done got=%0b exp=0", bus.o_busy); end
    checks++; if (bus.o_ack_rx !== 1'b0) begin errors++; $display("FAIL write_ack_rx got=%0b exp=0", bus.o_ack_rx); end
    checks++; if (bus.o_bit_cmd !== 3'b000) begin errors++; $display("FAIL write_cmd_at_done got=%b exp=000", bus.o_bit_cmd); end
    repeat (20) @(negedge clk);
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL write_done_count got=%0d exp=1", n_done - d0); end
    checks++; if (n_log - base !== 11) begin errors++; $display("FAIL write_bit_count got=%0d exp=11", n_log - base); end
    for (int k = 0; k < 11; k++) begin
      ec = (k == 0) ? 3'b001 : (k <= 8) ? 3'b010 : (k == 9) ? 3'b011 : 3'b100;
      checks++;
      if (log_cmd[base + k] !== ec) begin
        errors++; $display("FAIL write_seq_cmd[%0d] got=%b exp=%b", k, log_cmd[base + k], ec);
      end
      if (k >= 1 && k <= 8) begin
        checks++;
        if (log_dat[base + k] !== tx[8 - k]) begin
          errors++; $display("FAIL write_seq_data[%0d] got=%0b exp=%0b", k, log_dat[base + k], tx[8 - k]);
        end
      end
    end
  endtask

  task automatic test_read;
    int base;
    bit ok;
    logic [2:0] ec;
    resp_byte = 8'h3C;
    base = n_log;
    send(4'b0101, 8'h00, 1'b1);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_timeout got=no_done exp=done"); end
    checks++; if (bus.o_rx_byte !== 8'h3C) begin errors++; $display("FAIL read_rx_byte got=%h exp=3c", bus.o_rx_byte); end
    repeat (10) @(negedge clk);
    checks++; if (n_log - base !== 10) begin errors++; $display("FAIL read_bit_count got=%0d exp=10", n_log - base); end
    for (int k = 0; k < 10; k++) begin
      ec = (k < 8) ? 3'b011 : (k == 8) ? 3'b010 : 3'b100;
      checks++;
      if (log_cmd[base + k] !== ec) begin
        errors++; $display("FAIL read_seq_cmd[%0d] got=%b exp=%b", k, log_cmd[base + k], ec);
      end
    end
    checks++; if (log_dat[base + 8] !== 1'b1) begin errors++; $display("FAIL read_ack_level got=%0b exp=1", log_dat[base + 8]); end
  endtask

  task automatic test_busy;
    int base;
    int d0;
    bit ok;
    logic [7:0] tx;
    logic [2:0] ec;
    tx = 8'h5A;
    resp_byte = 8'hFF;
    base = n_log;
    d0 = n_done;
    send(4'b1110, tx, 1'b0);
    repeat (20) @(negedge clk);
    send(4'b0101, 8'h00, 1'b0);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_timeout got=no_done exp=done"); end
    repeat (100) @(negedge clk);
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", n_done - d0); end
    checks++; if (n_log - base !== 11) begin errors++; $display("FAIL busy_bit_count got=%0d exp=11", n_log - base); end
    checks++; if (bus.o_ack_rx !== 1'b1) begin errors++; $display("FAIL busy_nack got=%0b exp=1", bus.o_ack_rx); end
    checks++; if (bus.o_rx_byte !== 8'h3C) begin errors++; $display("FAIL busy_rx_kept got=%h exp=3c", bus.o_rx_byte); end
    for (int k = 0; k < 11; k++) begin
      ec = (k == 0) ? 3'b001 : (k <= 8) ? 3'b010 : (k == 9) ? 3'b011 : 3'b100;
      checks++;
      if (log_cmd[base + k] !== ec) begin
        errors++; $display("FAIL busy_seq_cmd[%0d] got=%b exp=%b", k, log_cmd[base + k], ec);
      end
      if (k >= 1 && k <= 8) begin
        checks++;
        if (log_dat[base + k] !== tx[8 - k]) begin
          errors++; $display("FAIL busy_seq_data[%0d] got=%0b exp=%0b", k, log_dat[base + k], tx[8 - k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int base;
    int d0;
    bit ok;
    base = n_log;
    d0 = n_done;
    send(4'b0100, 8'h00, 1'b0);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first got=no_done exp=done"); end
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = 4'b0100;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_done got=%0b exp=1", bus.o_busy); end
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second got=no_done exp=done"); end
    repeat (10) @(negedge clk);
    checks++; if (n_done - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", n_done - d0); end
    checks++; if (n_log - base !== 2) begin errors++; $display("FAIL b2b_bit_count got=%0d exp=2", n_log - base); end
    checks++; if (log_cmd[base + 1] !== 3'b100) begin errors++; $display("FAIL b2b_stop got=%b exp=100", log_cmd[base + 1]); end
  endtask

  task automatic test_reset_mid;
    int base;
    bit ok;
    resp_byte = 8'h00;
    base = n_log;
    ok = 1'b0;
    send(4'b1110, 8'hA5, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_log - base >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_progress got=%0d exp=4", n_log - base); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_bit_cmd !== 3'b000) begin errors++; $display("FAIL rstmid_bit_cmd got=%b exp=000", bus.o_bit_cmd); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", bus.o_busy); end
    checks++; if (bus.o_rx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_rx got=%h exp=00", bus.o_rx_byte); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = n_log;
    send(4'b0100, 8'h00, 1'b0);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_stop_timeout got=no_done exp=done"); end
    repeat (5) @(negedge clk);
    checks++; if (n_log - base !== 1) begin errors++; $display("FAIL rstmid_stop_count got=%0d exp=1", n_log - base); end
    checks++; if (log_cmd[base] !== 3'b100) begin errors++; $display("FAIL rstmid_stop_cmd got=%b exp=100", log_cmd[base]); end
    checks++; if (bus.o_ack_rx !== 1'b1) begin errors++; $display("FAIL rstmid_ack_rx got=%0b exp=1", bus.o_ack_rx); end
  endtask

  task automatic test_timeout;
    int cnt;
    model_en = 1'b0;
    send(4'b1000, 8'h00, 1'b0);
`ifdef I2C_BYTE_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.o_done) break;
    end
    checks++; if (cnt !== 17) begin errors++; $display("FAIL timeout_latency got=%0d exp=17", cnt); end
    checks++; if (bus.o_error !== 1'b1) begin errors++; $display("FAIL timeout_error got=%0b exp=1", bus.o_error); end
    checks++; if (bus.o_bit_cmd !== 3'b000) begin errors++; $display("FAIL timeout_cmd got=%b exp=000", bus.o_bit_cmd); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%0b exp=0", bus.o_busy); end
    @(negedge clk);
    checks++; if (bus.o_error !== 1'b0) begin errors++; $display("FAIL timeout_error_pulse got=%0b exp=0", bus.o_error); end
    checks++; if (n_err !== 1) begin errors++; $display("FAIL timeout_err_count got=%0d exp=1", n_err); end
`else
    cnt = 0;
    repeat (1000) @(negedge clk);
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL nowdog_busy got=%0b exp=1", bus.o_busy); end
    checks++; if (bus.o_bit_cmd !== 3'b001) begin errors++; $display("FAIL nowdog_cmd got=%b exp=001", bus.o_bit_cmd); end
    checks++; if (n_err !== cnt) begin errors++; $display("FAIL nowdog_err_count got=%0d exp=0", n_err); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    model_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    n_log = 0;
    n_done = 0;
    n_err = 0;
    model_en = 1'b1;
    resp_byte = 8'h00;
    rst_n = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = 4'b0000;
    bus.i_tx_byte = 8'h00;
    bus.i_ack_in = 1'b0;
    test_reset();
    test_empty();
    test_write();
    test_read();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
